fetch_unit: RTL and testbench

//  Instruction-fetch initiator for the single-cycle-memory CPU datapath. Owns the PC,

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_perf_counter.sv | 29 ++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath constants, opcodes and fetch FSM state type
package cpu_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h0;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0111;
    localparam logic [3:0] OP_BRN  = 4'b1011;
    localparam logic [3:0] OP_LD   = 4'b1110;
    localparam logic [3:0] OP_SVPC = 4'b1111;

    typedef enum logic [1:0] {
        S_START  = 2'd0,
        S_RUN    = 2'd1,
        S_SQUASH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_perf_counter.sv
// rtl/fetch_perf_counter.sv - one saturating 32-bit event counter
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner and IF/ID register with stall, redirect and squash
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/bubble_cnt performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = 32'd0,
    parameter int          IMEM_DEPTH    = 256,
    parameter int          SQUASH_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt,
    output logic [31:0] bubble_cnt,
`endif
    output logic        if_valid
);

    localparam logic [31:0] DEPTH   = 32'(IMEM_DEPTH);
    localparam logic [1:0]  SQ_LOAD = 2'(SQUASH_CYCLES);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  ifpc_q, ifpc_d;
    logic         valid_q, valid_d;
    logic [1:0]   sq_cnt_q, sq_cnt_d;
    logic [31:0]  pc_inc;

    assign pc_inc = (pc_q == DEPTH - 32'd1) ? 32'd0 : pc_q + 32'd1;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        ifpc_d   = ifpc_q;
        valid_d  = valid_q;
        sq_cnt_d = sq_cnt_q;
        // A redirect beats a stall: the wrong-path slot must be killed regardless.
        if (redirect_valid) begin
            pc_d     = redirect_pc % DEPTH;
            inst_d   = NOP_INST;
            ifpc_d   = pc_q;
            valid_d  = 1'b0;
            sq_cnt_d = SQ_LOAD;
            state_d  = (SQUASH_CYCLES > 0) ? S_SQUASH : S_RUN;
        end else if (!stall) begin
            case (state_q)
                S_START: begin
                    state_d = S_RUN;
                end
                S_RUN: begin
                    inst_d  = imem_inst;
                    ifpc_d  = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end
                S_SQUASH: begin
                    inst_d   = NOP_INST;
                    ifpc_d   = pc_q;
                    valid_d  = 1'b0;
                    pc_d     = pc_inc;
                    sq_cnt_d = sq_cnt_q - 2'd1;
                    if (sq_cnt_q == 2'd1) begin
                        state_d = S_RUN;
                    end
                end
                default: begin
                    state_d = S_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_START;
            pc_q     <= RESET_PC % DEPTH;
            inst_q   <= NOP_INST;
            ifpc_q   <= 32'd0;
            valid_q  <= 1'b0;
            sq_cnt_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            ifpc_q   <= ifpc_d;
            valid_q  <= valid_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_inst   = inst_q;
    assign if_pc     = ifpc_q;
    assign if_valid  = valid_q;

`ifdef FETCH_PERF_CNT_EN
    logic fetch_ev;
    logic bubble_ev;

    assign fetch_ev  = !redirect_valid && !stall && (state_q == S_RUN);
    assign bubble_ev = redirect_valid || (!stall && (state_q != S_RUN));

    fetch_perf_counter u_fetch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (fetch_ev),
        .cnt (fetch_cnt)
    );

    fetch_perf_counter u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .inc (bubble_ev),
        .cnt (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a negedge-sampled instruction memory
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem [0:255];

    logic [31:0] a0, a2, a16;
    logic [31:0] im0, im2, im16;
    logic        st0, st2, st16;
    logic        rv0, rv2, rv16;
    logic [31:0] rp0, rp2, rp16;
    logic [31:0] in0, in2, in16;
    logic [31:0] pc0, pc2, pc16;
    logic        v0, v2, v16;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc0, fc2, fc16, bc0, bc2, bc16;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        im0  <= mem[a0[7:0]];
        im2  <= mem[a2[7:0]];
        im16 <= mem[a16[7:0]];
    end

    fetch_unit #(.RESET_PC(32'd0), .IMEM_DEPTH(256), .SQUASH_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .imem_addr(a0), .imem_inst(im0), .stall(st0),
        .redirect_valid(rv0), .redirect_pc(rp0), .if_inst(in0), .if_pc(pc0),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fc0), .bubble_cnt(bc0),
`endif
        .if_valid(v0)
    );

    fetch_unit #(.RESET_PC(32'd0), .IMEM_DEPTH(256), .SQUASH_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .imem_addr(a2), .imem_inst(im2), .stall(st2),
        .redirect_valid(rv2), .redirect_pc(rp2), .if_inst(in2), .if_pc(pc2),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fc2), .bubble_cnt(bc2),
`endif
        .if_valid(v2)
    );

    fetch_unit #(.RESET_PC(32'd0), .IMEM_DEPTH(16), .SQUASH_CYCLES(0)) u16 (
        .clk(clk), .rst(rst), .imem_addr(a16), .imem_inst(im16), .stall(st16),
        .redirect_valid(rv16), .redirect_pc(rp16), .if_inst(in16), .if_pc(pc16),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fc16), .bubble_cnt(bc16),
`endif
        .if_valid(v16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h7104_1000;
        mem[9] = 32'h7202_1400;

        rst = 1'b1;
        {st0, st2, st16, rv0, rv2, rv16} = '0;
        rp0 = 0; rp2 = 0; rp16 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, v0}, 32'd0);
        check("rst_inst", in0, 32'h0);
        check("rst_pc", pc0, 32'd0);
        check("rst_addr", a0, 32'd0);
        check("rst_valid_u2", {31'd0, v2}, 32'd0);
        check("rst_addr_u16", a16, 32'd0);
        rst = 1'b0;

        // 1: start cycle is a bubble, then sequential fetch from 0
        step();
        check("t1_start_valid", {31'd0, v0}, 32'd0);
        check("t1_start_addr", a0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("t1_pc", pc0, 32'(k));
            check("t1_inst", in0, mem[k]);
            check("t1_valid", {31'd0, v0}, 32'd1);
        end

        // 2: stall three cycles at if_pc=2
        st0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_pc_hold", pc0, 32'd2);
            check("t2_inst_hold", in0, mem[2]);
            check("t2_valid_hold", {31'd0, v0}, 32'd1);
            check("t2_addr_hold", a0, 32'd3);
        end
        st0 = 1'b0;
        step();
        check("t2_release_pc", pc0, 32'd3);
        check("t2_release_inst", in0, mem[3]);

        // 3: redirect to 9 while pc=6, no extra squash
        step();
        step();
        check("t3_pre_addr", a0, 32'd6);
        rv0 = 1'b1; rp0 = 32'd9;
        step();
        rv0 = 1'b0;
        check("t3_bubble_valid", {31'd0, v0}, 32'd0);
        check("t3_bubble_inst", in0, 32'h0);
        check("t3_addr", a0, 32'd9);
        step();
        check("t3_pc", pc0, 32'd9);
        check("t3_inst", in0, 32'h7202_1400);
        check("t3_valid", {31'd0, v0}, 32'd1);

        // 4: SQUASH_CYCLES=2, redirect to 4 with stall in the same cycle
        rv2 = 1'b1; rp2 = 32'd4; st2 = 1'b1;
        step();
        rv2 = 1'b0; st2 = 1'b0;
        check("t4_b1_valid", {31'd0, v2}, 32'd0);
        check("t4_b1_inst", in2, 32'h0);
        check("t4_b1_addr", a2, 32'd4);
        step();
        check("t4_b2_valid", {31'd0, v2}, 32'd0);
        check("t4_b2_addr", a2, 32'd5);
        step();
        check("t4_b3_valid", {31'd0, v2}, 32'd0);
        check("t4_b3_inst", in2, 32'h0);
        check("t4_b3_addr", a2, 32'd6);
        step();
        check("t4_pc", pc2, 32'd6);
        check("t4_inst", in2, mem[6]);
        check("t4_valid", {31'd0, v2}, 32'd1);

        // 5: IMEM_DEPTH=16 wrap
        rv16 = 1'b1; rp16 = 32'd14;
        step();
        rv16 = 1'b0;
        check("t5_addr14", a16, 32'd14);
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_pc", pc16, 32'((14 + k) % 16));
            check("t5_inst", in16, mem[(14 + k) % 16]);
        end
        rv16 = 1'b1; rp16 = 32'd18;
        step();
        rv16 = 1'b0;
        check("t5_redir_addr", a16, 32'd2);
        step();
        check("t5_redir_pc", pc16, 32'd2);
        check("t5_redir_inst", in16, mem[2]);

        // 6: async reset while u2 is in S_SQUASH
        rv2 = 1'b1; rp2 = 32'd10;
        step();
        rv2 = 1'b0;
        check("t6_pre_addr", a2, 32'd10);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, v2}, 32'd0);
        check("t6_rst_inst", in2, 32'h0);
        check("t6_rst_pc", pc2, 32'd0);
        check("t6_rst_addr", a2, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t6_rst_fcnt", fc2, 32'd0);
        check("t6_rst_bcnt", bc2, 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        check("t6_start_valid", {31'd0, v2}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("t6_start_fcnt", fc2, 32'd0);
`endif
        for (int k = 0; k < 2; k++) begin
            step();
            check("t6_pc", pc2, 32'(k));
            check("t6_valid", {31'd0, v2}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
            check("t6_fcnt", fc2, 32'(k + 1));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
